// File: rtl/lp_fifo_pop_burst_adapter.sv
// Read-side adapter: drains an upstream FIFO via active-low pop into a 2-entry skid buffer,
// optionally gating pops into fixed-length bursts. Optional counters: LP_FIFO_POP_ADAPT_STATS_EN.
module lp_fifo_pop_burst_adapter #(
  parameter int unsigned Width    = 8,
  parameter int unsigned Depth    = 8,
  parameter int unsigned CntWidth = 4,
  parameter int unsigned TmoWidth = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [CntWidth-1:0] burst_len,
  input  logic [TmoWidth-1:0] timeout,
  input  logic                fifo_empty,
  input  logic [CntWidth-1:0] fifo_word_cnt,
  input  logic [Width-1:0]    fifo_data_out,
  input  logic                fifo_error,
  output logic                fifo_pop_n,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [Width-1:0]    out_data,
  output logic                out_last,
  output logic                busy,
  output logic                tmo_flag,
  output logic                sticky_err
`ifdef LP_FIFO_POP_ADAPT_STATS_EN
  ,
  output logic [31:0]         stat_words,
  output logic [31:0]         stat_stall
`endif
);

  typedef enum logic [1:0] {StIdle, StStream, StArm, StDrain} state_e;

  localparam logic [CntWidth-1:0] DepthC = CntWidth'(Depth);
  localparam logic [CntWidth-1:0] OneC   = CntWidth'(1);

  state_e              state_q, state_d;
  logic [CntWidth-1:0] len_q, len_d;
  logic [CntWidth-1:0] remain_q, remain_d;
  logic [TmoWidth-1:0] tmo_lim_q, tmo_lim_d;
  logic [TmoWidth-1:0] tmo_cnt_q, tmo_cnt_d;
  logic                tmo_flag_q, tmo_flag_d;
  logic                sticky_q, sticky_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [Width-1:0]    head_data_q, head_data_d, tail_data_q, tail_data_d;
  logic                head_last_q, head_last_d, tail_last_q, tail_last_d;

  logic                pop_permit, pop_ok, pop_last, rd;
  logic [CntWidth-1:0] clamped_len;

  assign clamped_len = (burst_len > DepthC) ? DepthC : burst_len;
  assign pop_permit  = ((state_q == StStream) && enable) || (state_q == StDrain);
  assign pop_ok      = !rst && !fifo_empty && (cnt_q != 2'd2) && pop_permit;
  assign pop_last    = (state_q == StDrain) && (remain_q == OneC);
  assign rd          = (cnt_q != 2'd0) && out_ready;

  // Burst / stream sequencing
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    remain_d   = remain_q;
    tmo_lim_d  = tmo_lim_q;
    tmo_cnt_d  = tmo_cnt_q;
    tmo_flag_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable) begin
          if (burst_len == '0) begin
            state_d = StStream;
          end else begin
            state_d   = StArm;
            len_d     = clamped_len;
            tmo_lim_d = timeout;
            tmo_cnt_d = '0;
          end
        end
      end
      StStream: begin
        if (!enable) state_d = StIdle;
      end
      StArm: begin
        if (!enable) begin
          state_d = StIdle;
        end else if (fifo_word_cnt >= len_q) begin
          state_d  = StDrain;
          remain_d = len_q;
        end else if ((tmo_lim_q != '0) && (tmo_cnt_q == tmo_lim_q) && (fifo_word_cnt != '0)) begin
          state_d    = StDrain;
          remain_d   = fifo_word_cnt;
          tmo_flag_d = 1'b1;
        end else if (tmo_cnt_q != tmo_lim_q) begin
          tmo_cnt_d = tmo_cnt_q + TmoWidth'(1);
        end
      end
      StDrain: begin
        if (pop_ok) begin
          remain_d = remain_q - OneC;
          if (remain_q == OneC) begin
            // A zero burst_len at the relatch point means streaming, not a zero-length burst
            if (!enable) begin
              state_d = StIdle;
            end else if (burst_len == '0) begin
              state_d = StStream;
            end else begin
              state_d   = StArm;
              len_d     = clamped_len;
              tmo_lim_d = timeout;
              tmo_cnt_d = '0;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Skid buffer: head feeds the stream, tail only holds a word while head is stalled
  always_comb begin
    cnt_d       = cnt_q;
    head_data_d = head_data_q;
    head_last_d = head_last_q;
    tail_data_d = tail_data_q;
    tail_last_d = tail_last_q;
    unique case ({pop_ok, rd})
      2'b10: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd0) begin
          head_data_d = fifo_data_out;
          head_last_d = pop_last;
        end else begin
          tail_data_d = fifo_data_out;
          tail_last_d = pop_last;
        end
      end
      2'b01: begin
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd2) begin
          head_data_d = tail_data_q;
          head_last_d = tail_last_q;
        end
      end
      2'b11: begin
        head_data_d = fifo_data_out;
        head_last_d = pop_last;
      end
      default: ;
    endcase
  end

  assign sticky_d = sticky_q | fifo_error;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      len_q       <= '0;
      remain_q    <= '0;
      tmo_lim_q   <= '0;
      tmo_cnt_q   <= '0;
      tmo_flag_q  <= 1'b0;
      sticky_q    <= 1'b0;
      cnt_q       <= 2'd0;
      head_data_q <= '0;
      head_last_q <= 1'b0;
      tail_data_q <= '0;
      tail_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      remain_q    <= remain_d;
      tmo_lim_q   <= tmo_lim_d;
      tmo_cnt_q   <= tmo_cnt_d;
      tmo_flag_q  <= tmo_flag_d;
      sticky_q    <= sticky_d;
      cnt_q       <= cnt_d;
      head_data_q <= head_data_d;
      head_last_q <= head_last_d;
      tail_data_q <= tail_data_d;
      tail_last_q <= tail_last_d;
    end
  end

`ifdef LP_FIFO_POP_ADAPT_STATS_EN
  logic [31:0] stat_words_q, stat_words_d, stat_stall_q, stat_stall_d;

  always_comb begin
    stat_words_d = stat_words_q + {31'd0, pop_ok};
    stat_stall_d = stat_stall_q + {31'd0, (cnt_q != 2'd0) && !out_ready};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_words_q <= '0;
      stat_stall_q <= '0;
    end else begin
      stat_words_q <= stat_words_d;
      stat_stall_q <= stat_stall_d;
    end
  end

  assign stat_words = stat_words_q;
  assign stat_stall = stat_stall_q;
`endif

  assign fifo_pop_n = !pop_ok;
  assign out_valid  = (cnt_q != 2'd0);
  assign out_data   = head_data_q;
  assign out_last   = head_last_q;
  assign busy       = (state_q != StIdle) || (cnt_q != 2'd0);
  assign tmo_flag   = tmo_flag_q;
  assign sticky_err = sticky_q;

endmodule

// File: tb/tb_lp_fifo_pop_burst_adapter.sv
// Bench for lp_fifo_pop_burst_adapter: cycle table, corner sequences, randomized scoreboard.
module tb_lp_fifo_pop_burst_adapter;

  logic       clk = 1'b0;
  logic       rst, enable, fifo_empty, fifo_error, out_ready;
  logic [3:0] burst_len, fifo_word_cnt;
  logic [7:0] timeout, fifo_data_out;
  logic       fifo_pop_n, out_valid, out_last, busy, tmo_flag, sticky_err;
  logic [7:0] out_data;
`ifdef LP_FIFO_POP_ADAPT_STATS_EN
  logic [31:0] stat_words, stat_stall;
`endif

  lp_fifo_pop_burst_adapter #(
    .Width(8), .Depth(8), .CntWidth(4), .TmoWidth(8)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .burst_len(burst_len), .timeout(timeout),
    .fifo_empty(fifo_empty), .fifo_word_cnt(fifo_word_cnt), .fifo_data_out(fifo_data_out),
    .fifo_error(fifo_error), .fifo_pop_n(fifo_pop_n), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .busy(busy),
    .tmo_flag(tmo_flag), .sticky_err(sticky_err)
`ifdef LP_FIFO_POP_ADAPT_STATS_EN
    , .stat_words(stat_words), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       push;
    logic [7:0] pdata;
    logic       en;
    logic [3:0] blen;
    logic [7:0] tmo;
    logic       e_pop;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_last;
    logic       e_tmo;
  } vec_t;

  vec_t       tv[$];
  logic [7:0] fq[$];
  logic [7:0] expq[$];
  logic [8:0] log_q[$];
  int         n_tests = 0, n_fail = 0, pop_empty = 0;
  logic       s_pop, s_valid, s_last, s_busy, s_tmo, s_err, s_ready;
  logic [7:0] s_data;
  logic [31:0] s_stall;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic update_fifo();
    fifo_empty    = (fq.size() == 0);
    fifo_word_cnt = 4'(fq.size());
    fifo_data_out = (fq.size() != 0) ? fq[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] d);
    fq.push_back(d);
    update_fifo();
  endtask

  // One clock: sample mid-cycle, let the upstream FIFO model react to the edge, settle inputs
  task automatic tick();
    @(negedge clk);
    s_pop = !fifo_pop_n; s_valid = out_valid; s_data = out_data; s_last = out_last;
    s_busy = busy; s_tmo = tmo_flag; s_err = sticky_err; s_ready = out_ready;
`ifdef LP_FIFO_POP_ADAPT_STATS_EN
    s_stall = stat_stall;
`else
    s_stall = 32'd0;
`endif
    if (s_valid === 1'b1 && s_ready === 1'b1) log_q.push_back({s_last, s_data});
    @(posedge clk);
    if (s_pop === 1'b1) begin
      if (fq.size() == 0) pop_empty++;
      else void'(fq.pop_front());
    end
    #1;
    update_fifo();
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; fifo_error = 1'b0; out_ready = 1'b1;
    fq.delete(); update_fifo();
    tick(); tick();
    rst = 1'b0;
    log_q.delete();
  endtask

  function automatic vec_t mk(input logic p, input logic [7:0] pd, input logic en,
                              input logic [3:0] bl, input logic [7:0] tm, input logic ep,
                              input logic ev, input logic [7:0] ed, input logic el,
                              input logic et);
    vec_t v;
    v.push = p; v.pdata = pd; v.en = en; v.blen = bl; v.tmo = tm;
    v.e_pop = ep; v.e_valid = ev; v.e_data = ed; v.e_last = el; v.e_tmo = et;
    return v;
  endfunction

  // Randomized run: words must emerge in push order; in burst mode every L-th word is last
  task automatic rand_segment(input logic [3:0] l, input int total);
    int   pushed = 0;
    logic p_valid = 1'b0, p_ready = 1'b0, p_last = 1'b0;
    logic [7:0] p_data = 8'h00, d;
    do_reset();
    expq.delete();
    burst_len = l; timeout = 8'd0; enable = 1'b1;
    for (int c = 0; c < 3000 && pushed < total; c++) begin
      if (fq.size() < 8 && $urandom_range(0, 1) == 1) begin
        d = 8'($urandom);
        push(d); expq.push_back(d); pushed++;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (p_valid && !p_ready) begin
        check("stall_valid", 32'(s_valid), 32'd1);
        check("stall_data", 32'({s_last, s_data}), 32'({p_last, p_data}));
      end
      p_valid = s_valid; p_ready = s_ready; p_data = s_data; p_last = s_last;
    end
    out_ready = 1'b1;
    for (int c = 0; c < 300 && log_q.size() < total; c++) tick();
    check("rand_count", 32'(log_q.size()), 32'(total));
    for (int i = 0; i < log_q.size() && i < expq.size(); i++) begin
      check("rand_data", 32'(log_q[i][7:0]), 32'(expq[i]));
      check("rand_last", 32'(log_q[i][8]), (l == 0) ? 32'd0 : 32'(((i + 1) % l) == 0));
    end
  endtask

  initial begin
    int   k;
    logic [7:0] hold;
    logic [31:0] st0;
    rst = 1'b1; enable = 1'b1; burst_len = 4'd0; timeout = 8'd0; fifo_error = 1'b1;
    out_ready = 1'b1; log_q.delete();
    fq.delete(); push(8'h55);

    // Reset: pop suppressed even with data waiting, error ignored while in reset
    tick(); tick();
    check("rst_pop_n", 32'(s_pop), 32'd0);
    check("rst_valid", 32'(s_valid), 32'd0);
    check("rst_data", 32'(s_data), 32'd0);
    check("rst_last", 32'(s_last), 32'd0);
    check("rst_busy", 32'(s_busy), 32'd0);
    check("rst_tmo", 32'(s_tmo), 32'd0);
    check("rst_err", 32'(s_err), 32'd0);
    do_reset();

    // Cycle table: streaming, threshold burst of 4, timeout burst of 2
    for (int i = 0; i < 3; i++) tv.push_back(mk(1, 8'hA1 + 8'(i * 17), 0, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 1, 0, 0, 0, 0, 8'h00, 0, 0));
    tv.push_back(mk(0, 0, 1, 0, 0, 1, 0, 8'h00, 0, 0));
    tv.push_back(mk(0, 0, 1, 0, 0, 1, 1, 8'hA1, 0, 0));
    tv.push_back(mk(0, 0, 1, 0, 0, 1, 1, 8'hB2, 0, 0));
    tv.push_back(mk(0, 0, 1, 0, 0, 0, 1, 8'hC3, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0));
    tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0));
    tv.push_back(mk(0, 0, 1, 4, 10, 0, 0, 8'h00, 0, 0));
    for (int i = 0; i < 4; i++) tv.push_back(mk(1, 8'h10 + 8'(i), 1, 4, 10, 0, 0, 0, 0, 0));
    tv.push_back(mk(0, 0, 1, 4, 10, 1, 0, 8'h00, 0, 0));
    tv.push_back(mk(0, 0, 1, 4, 10, 1, 1, 8'h10, 0, 0));
    tv.push_back(mk(0, 0, 1, 4, 10, 1, 1, 8'h11, 0, 0));
    tv.push_back(mk(0, 0, 1, 4, 10, 1, 1, 8'h12, 0, 0));
    tv.push_back(mk(1, 8'h20, 1, 4, 10, 0, 1, 8'h13, 1, 0));
    tv.push_back(mk(1, 8'h21, 1, 4, 10, 0, 0, 8'h00, 0, 0));
    for (int i = 0; i < 9; i++) tv.push_back(mk(0, 0, 1, 4, 10, 0, 0, 8'h00, 0, 0));
    tv.push_back(mk(0, 0, 1, 4, 10, 1, 0, 8'h00, 0, 1));
    tv.push_back(mk(0, 0, 1, 4, 10, 1, 1, 8'h20, 0, 0));
    tv.push_back(mk(0, 0, 1, 4, 10, 0, 1, 8'h21, 1, 0));
    tv.push_back(mk(0, 0, 1, 4, 10, 0, 0, 8'h00, 0, 0));
    for (int i = 0; i < tv.size(); i++) begin
      if (tv[i].push) push(tv[i].pdata);
      enable = tv[i].en; burst_len = tv[i].blen; timeout = tv[i].tmo; out_ready = 1'b1;
      tick();
      check($sformatf("tv%0d_pop", i), 32'(s_pop), 32'(tv[i].e_pop));
      check($sformatf("tv%0d_valid", i), 32'(s_valid), 32'(tv[i].e_valid));
      check($sformatf("tv%0d_tmo", i), 32'(s_tmo), 32'(tv[i].e_tmo));
      if (tv[i].e_valid) begin
        check($sformatf("tv%0d_data", i), 32'(s_data), 32'(tv[i].e_data));
        check($sformatf("tv%0d_last", i), 32'(s_last), 32'(tv[i].e_last));
      end
    end

    // Backpressure: five stalled cycles mid-stream
    do_reset();
    burst_len = 4'd0; timeout = 8'd0;
    for (int i = 0; i < 6; i++) push(8'h30 + 8'(i));
    enable = 1'b1;
    tick(); tick(); tick();
    out_ready = 1'b0;
    hold = 8'h00; st0 = 32'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 0) begin hold = s_data; st0 = s_stall; end
      check("bp_valid", 32'(s_valid), 32'd1);
      check("bp_hold", 32'(s_data), 32'(hold));
      if (i >= 1) check("bp_nopop", 32'(s_pop), 32'd0);
    end
    out_ready = 1'b1;
    tick();
`ifdef LP_FIFO_POP_ADAPT_STATS_EN
    check("bp_stat_stall", s_stall - st0, 32'd5);
`endif
    for (int c = 0; c < 30 && log_q.size() < 6; c++) tick();
    check("bp_count", 32'(log_q.size()), 32'd6);
    for (int i = 0; i < log_q.size() && i < 6; i++)
      check("bp_order", 32'(log_q[i]), 32'({1'b0, 8'h30 + 8'(i)}));

    // Clamp: burst_len 15 behaves as 8
    do_reset();
    burst_len = 4'd15; timeout = 8'd0;
    for (int i = 0; i < 8; i++) push(8'h40 + 8'(i));
    tick();
    enable = 1'b1; log_q.delete();
    for (int c = 0; c < 40 && log_q.size() < 8; c++) tick();
    tick(); tick(); tick();
    check("clamp_count", 32'(log_q.size()), 32'd8);
    for (int i = 0; i < log_q.size() && i < 8; i++)
      check("clamp_word", 32'(log_q[i]), 32'({(i == 7), 8'h40 + 8'(i)}));

    // Sticky error
    check("err_clear", 32'(s_err), 32'd0);
    fifo_error = 1'b1; tick(); fifo_error = 1'b0; tick();
    check("err_set", 32'(s_err), 32'd1);
    tick(); tick(); tick();
    check("err_hold", 32'(s_err), 32'd1);
    do_reset(); tick();
    check("err_rst", 32'(s_err), 32'd0);

    // Reset in the middle of a burst
    do_reset();
    burst_len = 4'd4; timeout = 8'd0;
    for (int i = 0; i < 4; i++) push(8'h60 + 8'(i));
    tick();
    enable = 1'b1;
    tick(); tick(); tick();
    check("mrst_draining", 32'(s_pop), 32'd1);
    rst = 1'b1; tick();
    check("mrst_pop_forced", 32'(s_pop), 32'd0);
    rst = 1'b0; tick();
    check("mrst_valid", 32'(s_valid), 32'd0);
    check("mrst_busy", 32'(s_busy), 32'd0);
    check("mrst_pop", 32'(s_pop), 32'd0);

    // Randomized traffic against the ordering / burst-boundary model
    rand_segment(4'd0, 60);
    rand_segment(4'd3, 60);
    rand_segment(4'd5, 60);
    check("no_pop_on_empty", 32'(pop_empty), 32'd0);

    k = n_fail;
    $display("[TB] %0d tests run, %0d failed", n_tests, k);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
